qspi_rx_shift_reg: RTL

Receive-side counterpart of the QSPI transmit shift register. It samples flash read data from IO[3:0] in single-, dual- or quad-line mode and assembles it MSB-first into DATA_W-bit words. It presents each word to the RX FIFO through a valid/ready handshake and reports overrun. It sits between the SCLK generator (sample strobes) and the AHB read FIFO.

---
 rtl/qspi_rx_shift_reg_pkg.sv | 20 ++
 rtl/qspi_rx_shift_reg_if.sv | 9 +
 rtl/qspi_rx_shift_reg_out_stage.sv | 37 +++
 rtl/qspi_rx_shift_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/qspi_rx_shift_reg_pkg.sv
// rtl/qspi_rx_shift_reg_pkg.sv - shared types, default width and mode decode for the QSPI receive path
package qspi_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [0:0] {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic [1:0] {IO_1, IO_2, IO_4} io_mode_t;

    // Widest requested mode wins; with nothing requested the bus falls back to single line.
    function automatic io_mode_t decode_mode(input logic u1, input logic u2, input logic u4);
        if (u4) begin
            return IO_4;
        end else if (u2) begin
            return IO_2;
        end else begin
            return IO_1;
        end
    endfunction

endpackage

// File: rtl/qspi_rx_shift_reg_if.sv
// rtl/qspi_rx_shift_reg_if.sv - received-word valid/ready channel toward the RX FIFO
interface qspi_rx_shift_reg_if #(parameter int DATA_W = qspi_pkg::DEFAULT_DATA_W);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/qspi_rx_shift_reg_out_stage.sv
// rtl/qspi_rx_shift_reg_out_stage.sv - output word register with valid/ready hold and sticky overrun
module qspi_rx_out_stage #(
    parameter int DATA_W = qspi_pkg::DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_overrun,
    input  logic              cap,
    input  logic [DATA_W-1:0] cap_word,
    qspi_rx_shift_reg_if.master rx_if,
    output logic              overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (clr_overrun) begin
                overrun <= 1'b0;
            end
            // A fresh word may replace the held one only if the holder is empty or draining now.
            if (cap) begin
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data  <= cap_word;
                    rx_if.rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/qspi_rx_shift_reg.sv
// rtl/qspi_rx_shift_reg.sv - QSPI 1/2/4-line receive shifter; QSPI_RX_BYTE_SWAP_EN adds byte_swap_in
module qspi_rx_shift_reg
    import qspi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             sample_en,
    input  logic             use_1_io_lines_in,
    input  logic             use_2_io_lines_in,
    input  logic             use_4_io_lines_in,
    input  logic [3:0]       qspi_io_in,
`ifdef QSPI_RX_BYTE_SWAP_EN
    input  logic             byte_swap_in,
`endif
    qspi_rx_shift_reg_if.master rx_if,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int BW = $clog2(DATA_W) + 1;

    rx_state_t         state;
    io_mode_t          mode_q;
    logic [DATA_W-2:0] sr;
    logic [BW-1:0]     bit_cnt;
    logic [CNT_W-1:0]  word_cnt;

    logic [DATA_W-1:0] sr_next;
    logic [DATA_W-1:0] cap_word;
    logic [BW-1:0]     step;
    logic [BW-1:0]     bit_next;
    logic              cap;
    logic              start_ok;

    // sr never needs its top bit: the completing sample lands straight in sr_next.
    always_comb begin
        step    = BW'(1);
        sr_next = {sr, qspi_io_in[1]};
        unique case (mode_q)
            IO_4: begin
                step    = BW'(4);
                sr_next = {sr[DATA_W-5:0], qspi_io_in};
            end
            IO_2: begin
                step    = BW'(2);
                sr_next = {sr[DATA_W-3:0], qspi_io_in[1:0]};
            end
            default: begin
                step    = BW'(1);
                sr_next = {sr, qspi_io_in[1]};
            end
        endcase
    end

    assign bit_next = bit_cnt + step;
    assign cap      = (state == RX_SHIFT) && sample_en && (bit_next == BW'(DATA_W));
    assign start_ok = (state == RX_IDLE) && start;
    assign busy     = (state == RX_SHIFT);

`ifdef QSPI_RX_BYTE_SWAP_EN
    logic swap_q;

    always_comb begin
        cap_word = sr_next;
        if (swap_q) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                cap_word[b*8 +: 8] = sr_next[DATA_W - 8 - b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_q <= 1'b0;
        end else if (start_ok) begin
            swap_q <= byte_swap_in;
        end
    end
`else
    assign cap_word = sr_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_IDLE;
            mode_q   <= IO_1;
            sr       <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (start) begin
                        state    <= RX_SHIFT;
                        mode_q   <= decode_mode(use_1_io_lines_in, use_2_io_lines_in, use_4_io_lines_in);
                        word_cnt <= (num_words == '0) ? CNT_W'(1) : num_words;
                        bit_cnt  <= '0;
                        sr       <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (sample_en) begin
                        sr <= sr_next[DATA_W-2:0];
                        if (cap) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_cnt - CNT_W'(1);
                            if (word_cnt == CNT_W'(1)) begin
                                state <= RX_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_next;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    qspi_rx_out_stage #(.DATA_W(DATA_W)) u_out_stage (
        .clk         (clk),
        .rst         (rst),
        .clr_overrun (start_ok),
        .cap         (cap),
        .cap_word    (cap_word),
        .rx_if       (rx_if),
        .overrun     (overrun)
    );

endmodule
